// File: rtl/life_ctrl_sequencer_pkg.sv
// Shared constants and FSM encoding for the life array control stage.
package life_ctrl_sequencer_pkg;

   localparam int ROWS      = 16;
   localparam int COLS      = 16;
   localparam int ROW_IDX_W = 4;
   localparam int CNT_W     = 24;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_STEP,
      S_SETTLE,
      S_FETCH,
      S_PRESENT,
      S_WAIT
   } state_e;

endpackage

// File: rtl/life_ctrl_sequencer_if.sv
// Row scan-out stream from the sequencer to the display/UART consumer.
interface life_ctrl_sequencer_if;
   import life_ctrl_sequencer_pkg::*;

   logic [COLS-1:0]      row_data;
   logic [ROW_IDX_W-1:0] row_idx;
   logic                 row_last;
   logic                 row_valid;
   logic                 row_ready;

   modport master (
      output row_data,
      output row_idx,
      output row_last,
      output row_valid,
      input  row_ready
   );

   modport slave (
      input  row_data,
      input  row_idx,
      input  row_last,
      input  row_valid,
      output row_ready
   );

endinterface

// File: rtl/life_ctrl_sequencer_timer.sv
// Saturating generation-period counter with synchronous clear.
module life_period_timer
   import life_ctrl_sequencer_pkg::*;
#(
   parameter int PERIOD = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (cnt_q != LAST) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == LAST);

endmodule

// File: rtl/life_ctrl_sequencer.sv
// Control stage for the 16x16 life array: pattern load, stepping, scan-out.
module life_ctrl_sequencer
   import life_ctrl_sequencer_pkg::*;
#(
   parameter int STEP_PERIOD = 1000,
   parameter int GEN_W       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cfg_wr,
   input  logic [ROW_IDX_W-1:0] cfg_addr,
   input  logic [COLS-1:0]      cfg_data,
   output logic                 cfg_ready,
   input  logic                 run,
   input  logic                 single_step,
   input  logic                 snap,
   output logic [COLS-1:0]      arr_vali,
   output logic [ROW_IDX_W-1:0] arr_vali_sel,
   output logic                 arr_write_enb,
   output logic                 arr_step,
   output logic [ROW_IDX_W-1:0] arr_valo_sel,
   input  logic [COLS-1:0]      arr_valo,
   life_ctrl_sequencer_if.master row_if,
   output logic [GEN_W-1:0]     generation,
   output logic                 busy
);

   localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ROWS - 1);

   state_e               state_q, state_d;
   logic [ROW_IDX_W-1:0] ptr_q, ptr_d;
   logic [COLS-1:0]      vali_q, vali_d;
   logic [ROW_IDX_W-1:0] vsel_q, vsel_d;
   logic [GEN_W-1:0]     gen_q, gen_d;
   logic [COLS-1:0]      data_q, data_d;
   logic                 first_q, first_d;
   logic                 single_q, single_d;
   logic                 period_done;

   life_period_timer #(
      .PERIOD (STEP_PERIOD)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (state_d == S_STEP),
      .done  (period_done)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      vali_d   = vali_q;
      vsel_d   = vsel_q;
      gen_d    = gen_q;
      single_d = single_q;
      first_d  = (state_q == S_FETCH);
      data_d   = first_q ? arr_valo : data_q;
      unique case (state_q)
         S_IDLE: begin
            if (cfg_wr) begin
               state_d = S_LOAD;
               vali_d  = cfg_data;
               vsel_d  = cfg_addr;
            end else if (single_step || run) begin
               state_d  = S_STEP;
               single_d = single_step;
            end else if (snap) begin
               state_d  = S_FETCH;
               single_d = 1'b1;
            end
         end
         S_LOAD: state_d = S_IDLE;
         S_STEP: begin
            gen_d   = gen_q + 1'b1;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            ptr_d   = '0;
            state_d = S_FETCH;
         end
         S_FETCH: state_d = S_PRESENT;
         S_PRESENT: begin
            // pointer wraps to 0 after the last row, ready for a snap
            if (row_if.row_ready) begin
               ptr_d = ptr_q + 1'b1;
               if (ptr_q != LAST_ROW) begin
                  state_d = S_FETCH;
               end else if (!single_q && run) begin
                  state_d = S_WAIT;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_WAIT: begin
            single_d = 1'b0;
            if (!run) begin
               state_d = S_IDLE;
            end else if (period_done) begin
               state_d = S_STEP;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         vali_q   <= '0;
         vsel_q   <= '0;
         gen_q    <= '0;
         data_q   <= '0;
         first_q  <= 1'b0;
         single_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         vali_q   <= vali_d;
         vsel_q   <= vsel_d;
         gen_q    <= gen_d;
         data_q   <= data_d;
         first_q  <= first_d;
         single_q <= single_d;
      end
   end

   assign cfg_ready     = (state_q == S_IDLE);
   assign busy          = (state_q != S_IDLE);
   assign arr_write_enb = (state_q == S_LOAD);
   assign arr_step      = (state_q == S_STEP);
   assign arr_vali      = vali_q;
   assign arr_vali_sel  = vsel_q;
   assign arr_valo_sel  = ptr_q;
   assign generation    = gen_q;

   // first PRESENT cycle shows the array readback directly, then the held copy
   assign row_if.row_data  = first_q ? arr_valo : data_q;
   assign row_if.row_idx   = ptr_q;
   assign row_if.row_valid = (state_q == S_PRESENT);
   assign row_if.row_last  = (state_q == S_PRESENT) && (ptr_q == LAST_ROW);

endmodule

// File: tb/tb_life_ctrl_sequencer.sv
// Bench for life_ctrl_sequencer: array model, stream monitor, scenario tasks.
module tb_life_ctrl_sequencer;
   import life_ctrl_sequencer_pkg::*;

   localparam int PERIOD = 100;

   typedef logic [15:0][15:0] grid_t;
   typedef struct packed {
      logic [3:0]  idx;
      logic        last;
      logic [15:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cfg_wr = 1'b0;
   logic [3:0]  cfg_addr = '0;
   logic [15:0] cfg_data = '0;
   logic        cfg_ready;
   logic        run = 1'b0;
   logic        single_step = 1'b0;
   logic        snap = 1'b0;
   logic [15:0] arr_vali;
   logic [3:0]  arr_vali_sel;
   logic        arr_write_enb;
   logic        arr_step;
   logic [3:0]  arr_valo_sel;
   logic [15:0] arr_valo;
   logic [15:0] generation;
   logic        busy;

   always #5 clk = ~clk;

   life_ctrl_sequencer_if rif ();

   life_ctrl_sequencer #(
      .STEP_PERIOD (PERIOD),
      .GEN_W       (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cfg_wr        (cfg_wr),
      .cfg_addr      (cfg_addr),
      .cfg_data      (cfg_data),
      .cfg_ready     (cfg_ready),
      .run           (run),
      .single_step   (single_step),
      .snap          (snap),
      .arr_vali      (arr_vali),
      .arr_vali_sel  (arr_vali_sel),
      .arr_write_enb (arr_write_enb),
      .arr_step      (arr_step),
      .arr_valo_sel  (arr_valo_sel),
      .arr_valo      (arr_valo),
      .row_if        (rif),
      .generation    (generation),
      .busy          (busy)
   );

   function automatic grid_t life_next(input grid_t g);
      grid_t n;
      n = '0;
      for (int r = 0; r < 16; r++) begin
         for (int c = 0; c < 16; c++) begin
            int k;
            k = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 16 &&
                      c + dc >= 0 && c + dc < 16)
                     k += int'(g[r+dr][c+dc]);
               end
            end
            n[r][c] = (k == 3) || (g[r][c] && k == 2);
         end
      end
      return n;
   endfunction

   grid_t arr_mem;
   always @(posedge clk) begin
      if (arr_write_enb) arr_mem[arr_vali_sel] <= arr_vali;
      if (arr_step) arr_mem <= life_next(arr_mem);
      arr_valo <= arr_mem[arr_valo_sel];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int    n_checks = 0;
   int    n_pass = 0;
   beat_t beats[$];
   int    step_cyc[$];
   int    wr_cnt = 0;
   int    overlap = 0;
   int    stab_err = 0;
   bit    rnd_ready = 1'b0;
   int    stall_idx = 0;
   int    stall_total = 0;
   int    stall_used = 0;
   bit    hold_v = 1'b0;
   beat_t held;

   always @(negedge clk) begin
      logic rdy;
      rdy = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rif.row_valid && stall_used < stall_total &&
          rif.row_idx == 4'(stall_idx)) begin
         rdy = 1'b0;
         stall_used++;
      end
      rif.row_ready = rdy;
      if (hold_v && (!rif.row_valid ||
          {rif.row_idx, rif.row_last, rif.row_data} !== held))
         stab_err++;
      hold_v = rif.row_valid && !rdy;
      held = {rif.row_idx, rif.row_last, rif.row_data};
      if (rif.row_valid && rdy) beats.push_back(held);
      if (arr_step) step_cyc.push_back(cyc);
      if (arr_write_enb) wr_cnt++;
      if (arr_step && arr_write_enb) overlap++;
   end

   grid_t ref_g = '0;
   int    gen_ref = 0;

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle(input string nm);
      int w;
      w = 0;
      while (busy && w < 2000) begin
         tick();
         w++;
      end
      n_checks++;
      if (busy !== 1'b0) $display("FAIL %s_idle busy=%b want 0", nm, busy);
      else n_pass++;
   endtask

   task automatic wait_beats(input int n, input string nm);
      int w;
      w = 0;
      while (beats.size() < n && w < 3000) begin
         tick();
         w++;
      end
      if (beats.size() < n) begin
         n_checks++;
         $display("FAIL %s_beats got %0d want %0d", nm, beats.size(), n);
      end
   endtask

   task automatic test_reset(input string nm);
      reset = 1'b0;
      #1;
      n_checks++;
      if ({busy, rif.row_valid, arr_step} !== 3'b000)
         $display("FAIL %s_async busy/valid/step=%b want 000", nm,
                  {busy, rif.row_valid, arr_step});
      else n_pass++;
      cfg_wr = 1'b0;
      run = 1'b0;
      single_step = 1'b0;
      snap = 1'b0;
      repeat (3) tick();
      gen_ref = 0;
      n_checks++;
      if (cfg_ready !== 1'b1) $display("FAIL %s_cfg_ready got %b want 1", nm, cfg_ready);
      else n_pass++;
      n_checks++;
      if ({busy, arr_write_enb, arr_step, rif.row_valid, rif.row_last} !== 5'b0)
         $display("FAIL %s_strobes got %b want 00000", nm,
                  {busy, arr_write_enb, arr_step, rif.row_valid, rif.row_last});
      else n_pass++;
      n_checks++;
      if ({arr_vali, arr_vali_sel, arr_valo_sel, rif.row_idx, rif.row_data} !== 52'b0)
         $display("FAIL %s_buses got %h want 0", nm,
                  {arr_vali, arr_vali_sel, arr_valo_sel, rif.row_idx, rif.row_data});
      else n_pass++;
      n_checks++;
      if (generation !== 16'(gen_ref))
         $display("FAIL %s_gen got %0d want %0d", nm, generation, gen_ref);
      else n_pass++;
      reset = 1'b1;
      tick();
   endtask

   task automatic test_load();
      int w0;
      w0 = wr_cnt;
      for (int r = 0; r < 16; r++) begin
         logic [15:0] d;
         int w;
         d = (r == 5) ? 16'h0070 : 16'h0000;
         w = 0;
         while (!cfg_ready && w < 100) begin
            tick();
            w++;
         end
         cfg_wr = 1'b1;
         cfg_addr = 4'(r);
         cfg_data = d;
         tick();
         cfg_wr = 1'b0;
         ref_g[r] = d;
         n_checks++;
         if ({arr_write_enb, cfg_ready, arr_vali_sel, arr_vali} !== {2'b10, 4'(r), d})
            $display("FAIL load_row%0d we/rdy/sel/data got %b/%b/%0d/%h want 1/0/%0d/%h",
                     r, arr_write_enb, cfg_ready, arr_vali_sel, arr_vali, r, d);
         else n_pass++;
         tick();
         n_checks++;
         if ({arr_write_enb, cfg_ready} !== 2'b01)
            $display("FAIL load_after%0d we/rdy got %b want 01", r, {arr_write_enb, cfg_ready});
         else n_pass++;
      end
      n_checks++;
      if (wr_cnt - w0 !== 16) $display("FAIL load_pulses got %0d want 16", wr_cnt - w0);
      else n_pass++;
   endtask

   task automatic test_snap();
      int b0, s0;
      wait_idle("snap_pre");
      b0 = beats.size();
      s0 = step_cyc.size();
      snap = 1'b1;
      tick();
      snap = 1'b0;
      wait_beats(b0 + 16, "snap");
      wait_idle("snap_post");
      for (int i = 0; i < 16; i++) begin
         beat_t e, a;
         e = {4'(i), 1'(i == 15), ref_g[i]};
         a = (b0 + i < beats.size()) ? beats[b0+i] : '0;
         n_checks++;
         if (a !== e) $display("FAIL snap_row%0d got %h want %h", i, a, e);
         else n_pass++;
      end
      n_checks++;
      if ({step_cyc.size() - s0, 16'(generation)} !== {32'd0, 16'd0})
         $display("FAIL snap_nostep steps=%0d gen=%0d want 0/0",
                  step_cyc.size() - s0, generation);
      else n_pass++;
   endtask

   task automatic test_blinker_step();
      int b0, s0;
      wait_idle("blink_pre");
      b0 = beats.size();
      s0 = step_cyc.size();
      single_step = 1'b1;
      tick();
      single_step = 1'b0;
      ref_g = life_next(ref_g);
      gen_ref++;
      wait_beats(b0 + 16, "blink");
      wait_idle("blink_post");
      for (int i = 0; i < 16; i++) begin
         beat_t e, a;
         e = {4'(i), 1'(i == 15), ref_g[i]};
         a = (b0 + i < beats.size()) ? beats[b0+i] : '0;
         n_checks++;
         if (a !== e) $display("FAIL blink_row%0d got %h want %h", i, a, e);
         else n_pass++;
      end
      for (int i = 4; i <= 6; i++) begin
         beat_t a;
         a = (b0 + i < beats.size()) ? beats[b0+i] : '0;
         n_checks++;
         if (a.data !== 16'h0020) $display("FAIL blink_vert%0d got %h want 0020", i, a.data);
         else n_pass++;
      end
      n_checks++;
      if (step_cyc.size() - s0 !== 1)
         $display("FAIL blink_steps got %0d want 1", step_cyc.size() - s0);
      else n_pass++;
      n_checks++;
      if (generation !== 16'(gen_ref))
         $display("FAIL blink_gen got %0d want %0d", generation, gen_ref);
      else n_pass++;
   endtask

   task automatic test_run();
      int b0, s0;
      wait_idle("run_pre");
      b0 = beats.size();
      s0 = step_cyc.size();
      run = 1'b1;
      wait_beats(b0 + 48, "run");
      run = 1'b0;
      wait_idle("run_post");
      for (int k = 0; k < 3; k++) begin
         ref_g = life_next(ref_g);
         gen_ref++;
         for (int i = 0; i < 16; i++) begin
            beat_t e, a;
            e = {4'(i), 1'(i == 15), ref_g[i]};
            a = (b0 + 16 * k + i < beats.size()) ? beats[b0+16*k+i] : '0;
            n_checks++;
            if (a !== e) $display("FAIL run_f%0d_row%0d got %h want %h", k, i, a, e);
            else n_pass++;
         end
      end
      n_checks++;
      if (step_cyc.size() - s0 !== 3)
         $display("FAIL run_steps got %0d want 3", step_cyc.size() - s0);
      else n_pass++;
      for (int k = 1; k < 3; k++) begin
         int dt;
         dt = (s0 + k < step_cyc.size()) ? step_cyc[s0+k] - step_cyc[s0+k-1] : -1;
         n_checks++;
         if (dt !== PERIOD) $display("FAIL run_period%0d got %0d want %0d", k, dt, PERIOD);
         else n_pass++;
      end
      n_checks++;
      if (generation !== 16'(gen_ref))
         $display("FAIL run_gen got %0d want %0d", generation, gen_ref);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int b0, s0, u0, e0;
      wait_idle("bp_pre");
      b0 = beats.size();
      s0 = step_cyc.size();
      u0 = stall_used;
      e0 = stab_err;
      stall_idx = 7;
      stall_total = stall_used + 5;
      single_step = 1'b1;
      tick();
      single_step = 1'b0;
      ref_g = life_next(ref_g);
      gen_ref++;
      wait_beats(b0 + 16, "bp");
      wait_idle("bp_post");
      repeat (4) tick();
      for (int i = 0; i < 16; i++) begin
         beat_t e, a;
         e = {4'(i), 1'(i == 15), ref_g[i]};
         a = (b0 + i < beats.size()) ? beats[b0+i] : '0;
         n_checks++;
         if (a !== e) $display("FAIL bp_row%0d got %h want %h", i, a, e);
         else n_pass++;
      end
      n_checks++;
      if (beats.size() - b0 !== 16) $display("FAIL bp_count got %0d want 16", beats.size() - b0);
      else n_pass++;
      n_checks++;
      if (stall_used - u0 !== 5) $display("FAIL bp_stall got %0d want 5", stall_used - u0);
      else n_pass++;
      n_checks++;
      if (stab_err - e0 !== 0) $display("FAIL bp_stable got %0d want 0", stab_err - e0);
      else n_pass++;
      n_checks++;
      if (step_cyc.size() - s0 !== 1) $display("FAIL bp_steps got %0d want 1", step_cyc.size() - s0);
      else n_pass++;
   endtask

   task automatic test_run_drop();
      int b0, s0, b1, b2, s2, w;
      wait_idle("drop_pre");
      b0 = beats.size();
      s0 = step_cyc.size();
      run = 1'b1;
      wait_beats(b0 + 3, "drop");
      w = 0;
      while (!rif.row_valid && w < 10) begin
         tick();
         w++;
      end
      run = 1'b0;
      ref_g = life_next(ref_g);
      gen_ref++;
      wait_idle("drop_post");
      repeat (4) tick();
      n_checks++;
      if (beats.size() - b0 !== 16) $display("FAIL drop_count got %0d want 16", beats.size() - b0);
      else n_pass++;
      for (int i = 0; i < 16; i++) begin
         beat_t e, a;
         e = {4'(i), 1'(i == 15), ref_g[i]};
         a = (b0 + i < beats.size()) ? beats[b0+i] : '0;
         n_checks++;
         if (a !== e) $display("FAIL drop_row%0d got %h want %h", i, a, e);
         else n_pass++;
      end
      n_checks++;
      if (step_cyc.size() - s0 !== 1) $display("FAIL drop_steps got %0d want 1", step_cyc.size() - s0);
      else n_pass++;
      b1 = beats.size();
      run = 1'b1;
      ref_g = life_next(ref_g);
      wait_beats(b1 + 5, "abort");
      test_reset("abort");
      b2 = beats.size();
      s2 = step_cyc.size();
      repeat (40) tick();
      n_checks++;
      if ({beats.size() - b2, step_cyc.size() - s2} !== 64'd0)
         $display("FAIL abort_quiet beats=%0d steps=%0d want 0/0",
                  beats.size() - b2, step_cyc.size() - s2);
      else n_pass++;
   endtask

   task automatic test_priority();
      int b0, s0;
      logic [15:0] d;
      wait_idle("prio_pre");
      b0 = beats.size();
      s0 = step_cyc.size();
      d = 16'($urandom);
      cfg_wr = 1'b1;
      cfg_addr = 4'd2;
      cfg_data = d;
      single_step = 1'b1;
      tick();
      cfg_wr = 1'b0;
      single_step = 1'b0;
      ref_g[2] = d;
      n_checks++;
      if ({arr_write_enb, arr_step, arr_vali} !== {2'b10, d})
         $display("FAIL prio_load we/step/data got %b/%b/%h want 1/0/%h",
                  arr_write_enb, arr_step, arr_vali, d);
      else n_pass++;
      repeat (6) tick();
      n_checks++;
      if ({beats.size() - b0, step_cyc.size() - s0, 31'd0, busy} !== 96'd0)
         $display("FAIL prio_drop beats=%0d steps=%0d busy=%b want 0/0/0",
                  beats.size() - b0, step_cyc.size() - s0, busy);
      else n_pass++;
      single_step = 1'b1;
      snap = 1'b1;
      tick();
      single_step = 1'b0;
      snap = 1'b0;
      ref_g = life_next(ref_g);
      gen_ref++;
      wait_beats(b0 + 16, "prio");
      wait_idle("prio_post");
      repeat (6) tick();
      n_checks++;
      if ({beats.size() - b0, step_cyc.size() - s0} !== {32'd16, 32'd1})
         $display("FAIL prio_once beats=%0d steps=%0d want 16/1",
                  beats.size() - b0, step_cyc.size() - s0);
      else n_pass++;
      for (int i = 0; i < 16; i++) begin
         beat_t e, a;
         e = {4'(i), 1'(i == 15), ref_g[i]};
         a = (b0 + i < beats.size()) ? beats[b0+i] : '0;
         n_checks++;
         if (a !== e) $display("FAIL prio_row%0d got %h want %h", i, a, e);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      rnd_ready = 1'b1;
      for (int it = 0; it < 8; it++) begin
         int b0, s0, op;
         int nrows;
         nrows = $urandom_range(1, 5);
         for (int j = 0; j < nrows; j++) begin
            logic [3:0]  r;
            logic [15:0] d;
            int w;
            r = 4'($urandom_range(0, 15));
            d = 16'($urandom);
            w = 0;
            while (!cfg_ready && w < 2000) begin
               tick();
               w++;
            end
            cfg_wr = 1'b1;
            cfg_addr = r;
            cfg_data = d;
            tick();
            cfg_wr = 1'b0;
            ref_g[r] = d;
            n_checks++;
            if ({arr_write_enb, arr_vali_sel, arr_vali} !== {1'b1, r, d})
               $display("FAIL rnd_load%0d got %b/%0d/%h want 1/%0d/%h",
                        it, arr_write_enb, arr_vali_sel, arr_vali, r, d);
            else n_pass++;
            tick();
         end
         b0 = beats.size();
         s0 = step_cyc.size();
         op = $urandom_range(0, 1);
         if (op == 1) begin
            single_step = 1'b1;
            ref_g = life_next(ref_g);
            gen_ref++;
         end else begin
            snap = 1'b1;
         end
         tick();
         single_step = 1'b0;
         snap = 1'b0;
         wait_beats(b0 + 16, "rnd");
         wait_idle("rnd_post");
         for (int i = 0; i < 16; i++) begin
            beat_t e, a;
            e = {4'(i), 1'(i == 15), ref_g[i]};
            a = (b0 + i < beats.size()) ? beats[b0+i] : '0;
            n_checks++;
            if (a !== e) $display("FAIL rnd%0d_row%0d got %h want %h", it, i, a, e);
            else n_pass++;
         end
         n_checks++;
         if ({step_cyc.size() - s0, 16'(generation)} !== {op, 16'(gen_ref)})
            $display("FAIL rnd%0d_step steps=%0d gen=%0d want %0d/%0d",
                     it, step_cyc.size() - s0, generation, op, gen_ref);
         else n_pass++;
      end
      rnd_ready = 1'b0;
   endtask

   task automatic test_invariants();
      n_checks++;
      if (overlap !== 0) $display("FAIL step_write_overlap got %0d want 0", overlap);
      else n_pass++;
      n_checks++;
      if (stab_err !== 0) $display("FAIL stream_hold got %0d want 0", stab_err);
      else n_pass++;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog timeout checks=%0d passed=%0d", n_checks, n_pass);
      $fatal(1);
   end

   initial begin
      test_reset("por");
      test_load();
      test_snap();
      test_blinker_step();
      test_run();
      test_backpressure();
      test_run_drop();
      test_priority();
      test_random();
      test_invariants();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
